// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC owner: next-PC select, run-control FSM (idle/run/drain/halted/trap),
// misaligned-redirect trap and saturating performance counters.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned DRAIN_CYC = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_halt_req,
  input  logic             i_stall_f,
  input  logic             i_jump,
  input  logic             i_branch,
  input  logic             i_fu_result_0,
  input  logic [31:0]      i_pc_plus4,
  input  logic [31:0]      i_pc_target,
  output logic [31:0]      o_pc,
  output logic             o_pcse,
  output logic             o_fetch_valid,
  output logic [2:0]       o_state,
  output logic [31:0]      o_trap_pc,
  output logic [CNT_W-1:0] o_cycle_cnt,
  output logic [CNT_W-1:0] o_fetch_cnt,
  output logic [CNT_W-1:0] o_redirect_cnt,
  output logic [CNT_W-1:0] o_stall_cnt
);

  localparam int unsigned DcW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [DcW-1:0] DrainLoad = DcW'(DRAIN_CYC - 1);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StRun    = 3'd1,
    StDrain  = 3'd2,
    StHalted = 3'd3,
    StTrap   = 3'd4
  } state_e;

  state_e           r_state, w_state_next;
  logic [31:0]      r_pc, w_pc_next;
  logic [31:0]      r_trap_pc, w_trap_pc_next;
  logic [DcW-1:0]   r_drain, w_drain_next;
  logic [CNT_W-1:0] r_cycle_cnt, r_fetch_cnt, r_redirect_cnt, r_stall_cnt;

  logic w_redirect_raw;
  logic w_in_run;
  logic w_active;
  logic w_misaligned;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

  assign w_redirect_raw = i_jump | (i_branch & i_fu_result_0);
  assign w_in_run       = (r_state == StRun);
  assign w_active       = w_in_run | (r_state == StDrain);
  // Only checked in RUN; DRAIN still flushes but never traps.
  assign w_misaligned   = w_in_run & w_redirect_raw & (i_pc_target[1:0] != 2'b00);

  assign o_pcse        = w_active & w_redirect_raw;
  assign o_fetch_valid = w_in_run & ~i_stall_f & ~w_redirect_raw;

  always_comb begin
    w_state_next   = r_state;
    w_pc_next      = r_pc;
    w_trap_pc_next = r_trap_pc;
    w_drain_next   = r_drain;
    unique case (r_state)
      StIdle: begin
        w_pc_next = RESET_PC;
        if (i_start) w_state_next = StRun;
      end
      StRun: begin
        if (w_misaligned) begin
          w_state_next   = StTrap;
          w_trap_pc_next = i_pc_target;
        end else begin
          if (w_redirect_raw) w_pc_next = i_pc_target;
          else if (!i_stall_f) w_pc_next = i_pc_plus4;
          if (i_halt_req) begin
            w_state_next = StDrain;
            w_drain_next = DrainLoad;
          end
        end
      end
      StDrain: begin
        if (r_drain == '0) w_state_next = StHalted;
        else               w_drain_next = r_drain - DcW'(1);
      end
      StHalted: begin
        if (i_start) begin
          w_pc_next    = RESET_PC;
          w_state_next = StRun;
        end
      end
      StTrap: ;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= StIdle;
      r_pc           <= RESET_PC;
      r_trap_pc      <= '0;
      r_drain        <= '0;
      r_cycle_cnt    <= '0;
      r_fetch_cnt    <= '0;
      r_redirect_cnt <= '0;
      r_stall_cnt    <= '0;
    end else begin
      r_state        <= w_state_next;
      r_pc           <= w_pc_next;
      r_trap_pc      <= w_trap_pc_next;
      r_drain        <= w_drain_next;
      r_cycle_cnt    <= sat_inc(r_cycle_cnt, w_active);
      r_fetch_cnt    <= sat_inc(r_fetch_cnt, o_fetch_valid);
      r_redirect_cnt <= sat_inc(r_redirect_cnt, w_in_run & w_redirect_raw & ~w_misaligned);
      r_stall_cnt    <= sat_inc(r_stall_cnt, w_in_run & i_stall_f & ~w_redirect_raw);
    end
  end

  assign o_pc           = r_pc;
  assign o_state        = r_state;
  assign o_trap_pc      = r_trap_pc;
  assign o_cycle_cnt    = r_cycle_cnt;
  assign o_fetch_cnt    = r_fetch_cnt;
  assign o_redirect_cnt = r_redirect_cnt;
  assign o_stall_cnt    = r_stall_cnt;

endmodule
